// File: rtl/up_input_port.sv
// Enter/Switches input stage: synchroniser, debounce FSM, operand holding register.
// Define UPIN_OVERRUN_EN to drop overrun captures and flag them on a sticky Overrun.
module up_input_port #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       Enter,
  input  logic [7:0] Switches,
  input  logic       Rd,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       Overrun,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic sync1, enter_s;
  logic capture;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1   <= 1'b0;
      enter_s <= 1'b0;
    end else begin
      sync1   <= Enter;
      enter_s <= sync1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The FSM leaves PRESS/RELEASE on the threshold, so cnt never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enter_s) begin
          cnt_nx = ONE_CNT;
          if (SINGLE) begin
            capture  = 1'b1;
            state_nx = HELD;
          end else begin
            state_nx = PRESS;
          end
        end
      end
      PRESS: begin
        if (!enter_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          capture  = 1'b1;
          state_nx = HELD;
        end else begin
          cnt_nx = cnt + ONE_CNT;
        end
      end
      HELD: begin
        if (!enter_s) begin
          cnt_nx   = ONE_CNT;
          state_nx = SINGLE ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (enter_s) begin
          state_nx = HELD;
        end else if (cnt == LAST) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + ONE_CNT;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

`ifdef UPIN_OVERRUN_EN
  // A capture with Rd on the same edge replaces the consumed operand.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Data    <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      if (capture && (!Valid || Rd)) begin
        Data  <= Switches;
        Valid <= 1'b1;
      end else if (Valid && Rd) begin
        Valid <= 1'b0;
      end
      if (capture && Valid && !Rd)
        Overrun <= 1'b1;
    end
  end
`else
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      Data  <= '0;
      Valid <= 1'b0;
    end else begin
      if (capture) begin
        Data  <= Switches;
        Valid <= 1'b1;
      end else if (Valid && Rd) begin
        Valid <= 1'b0;
      end
    end
  end

  assign Overrun = 1'b0;
`endif

endmodule

// File: tb/tb_up_input_port.sv
// Directed bench for up_input_port (DEBOUNCE_CYCLES=2): vector table plus corner sequences.
module tb_up_input_port;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       Enter = 1'b0;
  logic [7:0] Switches = 8'h00;
  logic       Rd = 1'b0;
  logic [7:0] Data;
  logic       Valid;
  logic       Overrun;
  logic       Busy;

  int n_chk = 0;
  int n_fail = 0;

`ifdef UPIN_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  up_input_port #(
    .DEBOUNCE_CYCLES(2),
    .CNT_W(16)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .Enter(Enter),
    .Switches(Switches),
    .Rd(Rd),
    .Data(Data),
    .Valid(Valid),
    .Overrun(Overrun),
    .Busy(Busy)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       en;
    logic [7:0] sw;
    logic       rd;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [7:0] sw, input logic rd,
                     input logic ev, input logic [7:0] ed, input logic eb);
    vec_t v;
    v.en = en;
    v.sw = sw;
    v.rd = rd;
    v.ev = ev;
    v.ed = ed;
    v.eb = eb;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 50) begin
      step();
      n++;
    end
    chk("wait_idle_busy", Busy, 0);
  endtask

  // Press with Enter high for hold cycles; Rd pulses on relative cycle rd_at.
  task automatic do_press(input logic [7:0] sw, input int hold,
                          input int rd_at);
    for (int i = 0; i < hold + 6; i++) begin
      @(negedge CLOCK);
      Enter = (i < hold);
      Switches = sw;
      Rd = (i == rd_at);
      step();
    end
    @(negedge CLOCK);
    Rd = 1'b0;
    wait_idle();
  endtask

  initial begin
    int seen;

    // glitch: one-cycle Enter pulse, rejected in PRESS
    add(1, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0);
    // A5 press: capture on the 4th edge of the press
    add(1, 8'hA5, 0, 0, 8'h00, 0);
    add(1, 8'hA5, 0, 0, 8'h00, 0);
    add(0, 8'hA5, 0, 0, 8'h00, 1);
    add(0, 8'hA5, 0, 1, 8'hA5, 1);
    add(0, 8'hA5, 0, 1, 8'hA5, 1);
    add(0, 8'hA5, 0, 1, 8'hA5, 0);
    add(0, 8'hA5, 1, 0, 8'hA5, 0);
    // 3C press held 4 cycles, consumed, then an ignored Rd
    add(1, 8'h3C, 0, 0, 8'hA5, 0);
    add(1, 8'h3C, 0, 0, 8'hA5, 0);
    add(1, 8'h3C, 0, 0, 8'hA5, 1);
    add(1, 8'h3C, 0, 1, 8'h3C, 1);
    add(0, 8'h3C, 0, 1, 8'h3C, 1);
    add(0, 8'h3C, 0, 1, 8'h3C, 1);
    add(0, 8'h3C, 0, 1, 8'h3C, 1);
    add(0, 8'h3C, 1, 0, 8'h3C, 0);
    add(0, 8'h3C, 1, 0, 8'h3C, 0);
    add(0, 8'h3C, 0, 0, 8'h3C, 0);

    step();
    step();
    chk("reset_data", Data, 0);
    chk("reset_valid", Valid, 0);
    chk("reset_overrun", Overrun, 0);
    chk("reset_busy", Busy, 0);
    @(negedge CLOCK);
    RESET = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLOCK);
      Enter = vt[i].en;
      Switches = vt[i].sw;
      Rd = vt[i].rd;
      step();
      chk($sformatf("row%0d_valid", i), Valid, vt[i].ev);
      chk($sformatf("row%0d_data", i), Data, vt[i].ed);
      chk($sformatf("row%0d_busy", i), Busy, vt[i].eb);
      chk($sformatf("row%0d_overrun", i), Overrun, 0);
    end

    // long hold with a mid-hold glitch; Rd follows Valid so each capture shows once
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK);
      Enter = (i < 20 && i != 10);
      Switches = 8'h5A;
      Rd = Valid;
      step();
      if (Valid)
        seen++;
    end
    @(negedge CLOCK);
    Rd = 1'b0;
    wait_idle();
    chk("hold_captures", seen, 1);
    chk("hold_data", Data, 8'h5A);
    chk("hold_valid", Valid, 0);

    // overrun: second press without Rd
    do_press(8'h11, 4, -1);
    chk("ovr_first_valid", Valid, 1);
    chk("ovr_first_data", Data, 8'h11);
    chk("ovr_first_flag", Overrun, 0);
    do_press(8'h22, 4, -1);
    chk("ovr_second_valid", Valid, 1);
    chk("ovr_second_data", Data, OVR ? 8'h11 : 8'h22);
    chk("ovr_second_flag", Overrun, OVR);

    // Rd on the capture edge: capture wins, no new overrun
    do_press(8'h77, 4, 3);
    chk("rdcap_valid", Valid, 1);
    chk("rdcap_data", Data, 8'h77);
    chk("rdcap_overrun", Overrun, OVR);

    // reset while in PRESS
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK);
      Enter = 1'b1;
      Switches = 8'h99;
      step();
    end
    chk("midpress_busy", Busy, 1);
    RESET = 1'b1;
    #1;
    chk("rst_async_data", Data, 0);
    chk("rst_async_valid", Valid, 0);
    chk("rst_async_overrun", Overrun, 0);
    chk("rst_async_busy", Busy, 0);
    Enter = 1'b0;
    step();
    step();
    @(negedge CLOCK);
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_rst%0d_valid", i), Valid, 0);
      chk($sformatf("post_rst%0d_busy", i), Busy, 0);
    end
    chk("post_rst_data", Data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
